// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
//
// Responder end of the CPU data bus. It holds the data RAM, which supports
// byte-lane writes, and a 16-byte MMIO window with four registers:
//   +0x0 GPIO     output register, read back zero-extended
//   +0x4 COUNTER  free-running cycle counter, read-only
//   +0x8 COMPARE  timer compare value
//   +0xC STATUS   sticky flags, cleared by writing 1 to a bit
//                 [0] timer match  [1] bad size/alignment  [2] unmapped write
//
// Reads are combinational, so a single-cycle core sees load data in the same
// cycle. Writes and all state updates happen on the rising clk edge.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous reset, active low (0 = in reset)
//   bus_address       byte address from the core
//   bus_wr_data       store data, right-aligned
//   bus_write_length  store size (funct3): 000 byte, 001 half, 010 word
//   bus_wr_enable     write strobe, sampled at the rising edge
//   bus_read_data     aligned word at bus_address[31:2], combinational
//   gpio_out          GPIO register value
//   timer_irq         STATUS[0]
// -----------------------------------------------------------------------------
module data_bus_responder #(
  parameter int          DATA_MEMORY_SIZE_WORDS = 256,
  parameter logic [31:0] MMIO_BASE              = 32'h8000_0000,
  parameter int          GPIO_WIDTH             = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           bus_address,
  input  logic [31:0]           bus_wr_data,
  input  logic [2:0]            bus_write_length,
  input  logic                  bus_wr_enable,
  output logic [31:0]           bus_read_data,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  localparam int          IDX_W     = (DATA_MEMORY_SIZE_WORDS > 1) ? $clog2(DATA_MEMORY_SIZE_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DATA_MEMORY_SIZE_WORDS);

  typedef enum logic [2:0] {
    LEN_BYTE = 3'b000,
    LEN_HALF = 3'b001,
    LEN_WORD = 3'b010
  } len_e;

  typedef enum logic [1:0] {
    REG_GPIO    = 2'd0,
    REG_COUNTER = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_e;

  // Storage
  logic [31:0]           mem [DATA_MEMORY_SIZE_WORDS];
  logic [GPIO_WIDTH-1:0] gpio_q;
  logic [31:0]           counter_q;
  logic [31:0]           compare_q;
  logic [2:0]            status_q;

  // Address decode
  logic             ram_hit;
  logic             mmio_hit;
  logic [IDX_W-1:0] word_idx;
  reg_e             reg_sel;

  assign ram_hit  = (bus_address < RAM_BYTES);
  assign mmio_hit = (bus_address[31:4] == MMIO_BASE[31:4]);
  assign word_idx = bus_address[IDX_W+1:2];
  assign reg_sel  = reg_e'(bus_address[3:2]);

  // Write decode
  logic [3:0]  lane_en;
  logic [31:0] lane_data;
  logic        align_err;
  logic        unmapped_err;
  logic        gpio_we;
  logic        compare_we;
  logic [2:0]  status_clr;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    lane_en      = 4'b0000;
    lane_data    = {4{bus_wr_data[7:0]}};
    align_err    = 1'b0;
    unmapped_err = 1'b0;
    gpio_we      = 1'b0;
    compare_we   = 1'b0;
    status_clr   = 3'b000;

    if (bus_wr_enable) begin
      if (ram_hit) begin
        // Store data is replicated across lanes so each enabled lane simply
        // takes its own byte position from lane_data.
        case (bus_write_length)
          LEN_BYTE: lane_en = 4'b0001 << bus_address[1:0];
          LEN_HALF: begin
            lane_data = {2{bus_wr_data[15:0]}};
            if (bus_address[0]) align_err = 1'b1;
            else                lane_en   = bus_address[1] ? 4'b1100 : 4'b0011;
          end
          LEN_WORD: begin
            lane_data = bus_wr_data;
            if (bus_address[1:0] != 2'b00) align_err = 1'b1;
            else                           lane_en   = 4'b1111;
          end
          default:  align_err = 1'b1;
        endcase
      end else if (mmio_hit) begin
        if (bus_write_length != LEN_WORD || bus_address[1:0] != 2'b00) begin
          align_err = 1'b1;
        end else begin
          case (reg_sel)
            REG_GPIO:    gpio_we    = 1'b1;
            REG_COMPARE: compare_we = 1'b1;
            REG_STATUS:  status_clr = bus_wr_data[2:0];
            default:     ;  // COUNTER is read-only; the write is ignored.
          endcase
        end
      end else begin
        unmapped_err = 1'b1;
      end
    end
  end

  // Data RAM
  // NOTE: the RAM array has no reset; clearing it would turn the memory into
  // flops. Its contents are undefined until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      // Gating on reset drops a store presented while reset is held.
      if (reset && lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
    end
  end

  // MMIO registers
  logic [2:0] status_set;

  // The match uses the current COMPARE, so a same-cycle COMPARE write still
  // compares against the old value.
  assign status_set = {unmapped_err, align_err, (counter_q == compare_q)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q    <= '0;
      counter_q <= '0;
      compare_q <= 32'hFFFF_FFFF;
      status_q  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      counter_q <= counter_q + 32'd1;
      if (gpio_we)    gpio_q    <= bus_wr_data[GPIO_WIDTH-1:0];
      if (compare_we) compare_q <= bus_wr_data;
      // A set event and a clear on the same bit in one cycle: set wins.
      status_q <= (status_q & ~status_clr) | status_set;
    end
  end

  // Read path
  always_comb begin
    bus_read_data = 32'h0000_0000;
    if (ram_hit) begin
      bus_read_data = mem[word_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_GPIO:    bus_read_data = 32'(gpio_q);
        REG_COUNTER: bus_read_data = counter_q;
        REG_COMPARE: bus_read_data = compare_q;
        default:     bus_read_data = {29'b0, status_q};
      endcase
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = status_q[0];

endmodule

// File: tb/tb_data_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_data_bus_responder
//
// Bench for data_bus_responder. A byte-array reference model of the memory
// map runs alongside the DUT; a table of directed vectors, hand-written timer
// and reset sequences, and a randomized phase are all compared against it.
// -----------------------------------------------------------------------------
module tb_data_bus_responder;

  localparam int          WORDS     = 256;
  localparam int          RAM_BYTES = 4 * WORDS;
  localparam logic [31:0] MMIO      = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] bus_address;
  logic [31:0] bus_wr_data;
  logic [2:0]  bus_write_length;
  logic        bus_wr_enable;
  logic [31:0] bus_read_data;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  data_bus_responder #(
    .DATA_MEMORY_SIZE_WORDS(WORDS),
    .MMIO_BASE(MMIO),
    .GPIO_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_address(bus_address),
    .bus_wr_data(bus_wr_data),
    .bus_write_length(bus_write_length),
    .bus_wr_enable(bus_wr_enable),
    .bus_read_data(bus_read_data),
    .gpio_out(gpio_out),
    .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the memory map as a flat byte array plus register values.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_mem   [RAM_BYTES];
  bit          m_known [RAM_BYTES];
  logic [31:0] m_gpio;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic [2:0]  m_status;

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(RAM_BYTES);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= MMIO) && (a < MMIO + 32'd16);
  endfunction

  task automatic model_reset();
    m_gpio   = 0;
    m_cnt    = 0;
    m_cmp    = 32'hFFFF_FFFF;
    m_status = 0;
  endtask

  function automatic bit model_known(input logic [31:0] a);
    int base;
    if (!is_ram(a)) return 1'b1;
    base = int'(a) & ~3;
    return m_known[base] && m_known[base+1] && m_known[base+2] && m_known[base+3];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int base;
    if (is_ram(a)) begin
      base = int'(a) & ~3;
      return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    end
    if (is_mmio(a)) begin
      case ((a - MMIO) / 4)
        0:       return m_gpio;
        1:       return m_cnt;
        2:       return m_cmp;
        default: return {29'b0, m_status};
      endcase
    end
    return 0;
  endfunction

  // Apply one clock edge's worth of effects for the given bus inputs.
  task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] len, input logic we);
    logic [2:0] set_b;
    logic [2:0] clr_b;
    int         nbytes;
    set_b  = 0;
    clr_b  = 0;
    nbytes = 0;
    if (m_cnt == m_cmp) set_b[0] = 1'b1;
    if (we) begin
      if (is_ram(a)) begin
        if (len == 0)                  nbytes = 1;
        else if (len == 1 && a % 2 == 0) nbytes = 2;
        else if (len == 2 && a % 4 == 0) nbytes = 4;
        else                           set_b[1] = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
          m_mem[int'(a) + k]   = d[8*k +: 8];
          m_known[int'(a) + k] = 1'b1;
        end
      end else if (is_mmio(a)) begin
        if (len != 2 || a % 4 != 0) set_b[1] = 1'b1;
        else if (a == MMIO)         m_gpio = d & 32'hFF;
        else if (a == MMIO + 8)     m_cmp  = d;
        else if (a == MMIO + 12)    clr_b  = d[2:0];
      end else begin
        set_b[2] = 1'b1;
      end
    end
    m_status = (m_status & ~clr_b) | set_b;
    m_cnt    = m_cnt + 1;
  endtask

  // One bus cycle: drive at the falling edge, sample 1 time unit later,
  // then let the rising edge commit and advance the model.
  task automatic drive_cycle(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] len, input logic we,
                             input logic chk, input logic [31:0] exp,
                             input string name);
    @(negedge clk);
    bus_address      = a;
    bus_wr_data      = d;
    bus_write_length = len;
    bus_wr_enable    = we;
    #1;
    if (model_known(a)) check({name, "_model"}, bus_read_data, model_read(a));
    if (chk)            check(name, bus_read_data, exp);
    check("gpio_model", 32'(gpio_out), m_gpio);
    check("irq_model", {31'b0, timer_irq}, {31'b0, m_status[0]});
    @(posedge clk);
    model_step(a, d, len, we);
  endtask

  // Assert reset at a falling edge, verify the asynchronous clear before any
  // clock edge, show that a write presented during reset is lost, and release
  // just after the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b0;
    bus_address      = MMIO + 32'h4;
    bus_wr_enable    = 1'b0;
    bus_write_length = 3'b010;
    #1;
    check("rst_counter", bus_read_data, 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_irq", {31'b0, timer_irq}, 32'h0);
    bus_address = MMIO + 32'hC;
    #1;
    check("rst_status", bus_read_data, 32'h0);
    bus_address = MMIO + 32'h8;
    #1;
    check("rst_compare", bus_read_data, 32'hFFFF_FFFF);
    bus_address   = MMIO;
    bus_wr_data   = 32'h33;
    bus_wr_enable = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    check("rst_write_lost", 32'(gpio_out), 32'h0);
    bus_wr_enable = 1'b0;
    reset         = 1'b1;
  endtask

  // Directed vector table
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
    logic        we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len,
                              input logic we, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.addr = a; v.data = d; v.len = len; v.we = we; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010;

  initial begin
    logic [31:0] a;
    logic [2:0]  len;

    // Vectors start in the first cycle after reset release, so entry i sees
    // COUNTER == i.
    add(MMIO + 4,  0, W, 0, 1, 32'd0);
    add(MMIO + 4,  0, W, 0, 1, 32'd1);
    add(MMIO + 4,  0, W, 0, 1, 32'd2);
    add(MMIO + 4,  0, W, 0, 1, 32'd3);
    add(MMIO + 8,  0, W, 0, 1, 32'hFFFF_FFFF);
    add(MMIO + 12, 0, W, 0, 1, 32'h0);
    add(32'h20, 32'h0BAD_F00D, W, 1, 0, 0);
    add(32'h10, 32'hDEAD_BEEF, W, 1, 0, 0);
    add(32'h11, 32'hAAAA_AA55, B, 1, 1, 32'hDEAD_BEEF);
    add(32'h12, 32'h5555_1234, H, 1, 1, 32'hDEAD_55EF);
    add(32'h10, 0, W, 0, 1, 32'h1234_55EF);
    add(32'h13, 32'hFFFF_FFFF, H, 1, 1, 32'h1234_55EF);
    add(32'h22, 32'h1111_1111, W, 1, 1, 32'h0BAD_F00D);
    add(32'h10, 0, W, 0, 1, 32'h1234_55EF);
    add(32'h20, 0, W, 0, 1, 32'h0BAD_F00D);
    add(MMIO + 12, 0, W, 0, 1, 32'h2);
    add(MMIO + 12, 32'h2, W, 1, 1, 32'h2);
    add(MMIO + 12, 0, W, 0, 1, 32'h0);
    add(MMIO,      32'hA5, W, 1, 1, 32'h0);
    add(MMIO,      0, W, 0, 1, 32'hA5);
    add(MMIO,      32'h00, B, 1, 1, 32'hA5);
    add(MMIO,      0, W, 0, 1, 32'hA5);
    add(MMIO + 12, 0, W, 0, 1, 32'h2);
    add(32'h4000_0000, 32'h1234_5678, W, 1, 1, 32'h0);
    add(32'h4000_0000, 0, W, 0, 1, 32'h0);
    add(MMIO + 12, 0, W, 0, 1, 32'h6);
    add(MMIO + 12, 32'h6, W, 1, 1, 32'h6);
    add(MMIO + 12, 0, W, 0, 1, 32'h0);
    add(MMIO + 4,  32'h7, W, 1, 1, 32'd28);
    add(MMIO + 4,  0, W, 0, 1, 32'd29);
    add(MMIO + 12, 0, W, 0, 1, 32'h0);
    add(32'h30, 32'h9999_9999, 3'b011, 1, 0, 0);
    add(MMIO + 12, 0, W, 0, 1, 32'h2);
    add(32'h400, 32'h77, B, 1, 1, 32'h0);
    add(MMIO + 12, 0, W, 0, 1, 32'h6);
    add(MMIO + 12, 32'h7, W, 1, 1, 32'h6);
    add(MMIO + 12, 0, W, 0, 1, 32'h0);
    add(32'h3FC, 32'hCAFE_F00D, W, 1, 0, 0);
    add(32'h3FC, 0, W, 0, 1, 32'hCAFE_F00D);

    // Initial reset
    reset            = 1'b0;
    bus_address      = MMIO + 32'h8;
    bus_wr_data      = 0;
    bus_write_length = W;
    bus_wr_enable    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("init_gpio", 32'(gpio_out), 32'h0);
    check("init_irq", {31'b0, timer_irq}, 32'h0);
    check("init_compare", bus_read_data, 32'hFFFF_FFFF);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].addr, vecs[i].data, vecs[i].len, vecs[i].we,
                  vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Timer: COMPARE=10 in the first cycle after reset.
    do_reset();
    drive_cycle(MMIO + 8, 32'd10, W, 1, 1, 32'hFFFF_FFFF, "cmp_write");
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(MMIO + 4, 0, W, 0, 1, 32'(i), "tmr_count");
      #2;
      check($sformatf("tmr_irq_after_%0d", i), {31'b0, timer_irq}, {31'b0, (i >= 10)});
    end
    // Same-cycle match and clear on STATUS[0]: the set wins.
    drive_cycle(MMIO + 8,  32'd15, W, 1, 1, 32'd10, "cmp_rewrite");
    drive_cycle(MMIO + 4,  0,      W, 0, 1, 32'd14, "tmr_count14");
    drive_cycle(MMIO + 12, 32'h1,  W, 1, 1, 32'h1,  "clr_at_match");
    #2;
    check("set_wins", {31'b0, timer_irq}, 32'h1);
    drive_cycle(MMIO + 12, 32'h1, W, 1, 1, 32'h1, "clr_plain");
    #2;
    check("irq_cleared", {31'b0, timer_irq}, 32'h0);

    // Run to COUNTER ~500 with GPIO=0xFF, then reset mid-run.
    drive_cycle(MMIO, 32'hFF, W, 1, 0, 0, "gpio_ff");
    for (int n = 0; n < 1000 && m_cnt < 500; n++) begin
      drive_cycle(MMIO + 4, 0, W, 0, 0, 0, "run");
    end
    check("gpio_before_reset", 32'(gpio_out), 32'hFF);
    do_reset();

    // Fill RAM, then random traffic against the model.
    for (int w = 0; w < WORDS; w++) begin
      drive_cycle(32'(4 * w), $urandom, W, 1, 0, 0, "fill");
    end
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = 32'($urandom_range(0, RAM_BYTES - 1));
        2:       a = MMIO + 32'($urandom_range(0, 15));
        3:       a = 32'(RAM_BYTES - 4) + 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 9) < 7) len = 3'($urandom_range(0, 2));
      else                          len = 3'($urandom_range(0, 7));
      drive_cycle(a, $urandom, len, 1'($urandom_range(0, 1)), 0, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
